// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if -- command handshake between game logic and the PS/2 host
// transmitter.
//   tx_data  : command byte to send (sampled on accept)
//   tx_valid : send request, accepted when tx_valid & tx_ready
//   tx_ready : transmitter idle and able to accept a byte
//   busy     : transfer in progress; keyboard receiver ignores the line
//   tx_done  : one-cycle pulse when a transfer ends (success or failure)
//   tx_error : one-cycle pulse with tx_done on no-ack or timeout
// master = game logic side, slave = transmitter side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter. Pulls the keyboard clock
// low to inhibit, issues request-to-send, then presents data/parity/stop on
// the device's falling clock edges and checks the device acknowledge.
//   clock      : system clock (CLOCK_50)
//   resetn     : asynchronous active-low reset
//   host       : command handshake (ps2_host_tx_if.slave)
//   ps2_clk_in : raw PS2_KBCLK pin level
//   ps2_dat_in : raw PS2_KBDAT pin level
//   ps2_clk_oe : 1 = pull PS2_KBCLK low (top level drives oe ? 0 : z)
//   ps2_dat_oe : 1 = pull PS2_KBDAT low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic         clock,
  input  logic         resetn,
  ps2_host_tx_if.slave host,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LAST    = 20'(XFER_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_FIRST,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t      state, state_d;
  logic [19:0] timer, timer_d;
  logic [3:0]  edge_cnt, edge_cnt_d;   // falling edges seen, 1-based
  logic [9:0]  shift_q, shift_d;       // {stop, parity, data}, LSB first
  logic        clk_oe_d, dat_oe_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_error_q, tx_error_d;

  // Pin synchronizer and falling-edge detector.
  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       clk_s, dat_s, clk_fall;

  // NOTE: the synchronizer resets to the idle-high line level, otherwise the
  // first cycles after reset would see a phantom falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign clk_fall = clk_prev & ~clk_s;

  // State register plus registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      timer      <= '0;
      edge_cnt   <= '0;
      shift_q    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      edge_cnt   <= edge_cnt_d;
      shift_q    <= shift_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  // Next-state logic. A falling edge always beats a timeout in the same cycle.
  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:       if (host.tx_valid) state_d = S_INHIBIT;
      S_INHIBIT:    if (timer == INHIBIT_LAST) state_d = S_RTS;
      S_RTS:        state_d = S_WAIT_FIRST;
      S_WAIT_FIRST: begin
        if (clk_fall)                 state_d = S_SHIFT;
        else if (timer == START_LAST) state_d = S_FAIL;
      end
      S_SHIFT: begin
        if (clk_fall) begin
          if (edge_cnt == 4'd9) state_d = S_ACK;   // this is edge 10
        end else if (timer == XFER_LAST) begin
          state_d = S_FAIL;
        end
      end
      S_ACK: begin
        if (clk_fall)                state_d = dat_s ? S_FAIL : S_WAIT_IDLE;
        else if (timer == XFER_LAST) state_d = S_FAIL;
      end
      S_WAIT_IDLE: begin
        if (clk_s && dat_s)          state_d = S_DONE;
        else if (timer == XFER_LAST) state_d = S_FAIL;
      end
      S_DONE, S_FAIL: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath and output decode; outputs are computed from the next state so
  // the registered copies line up with the state they belong to.
  always_comb begin
    timer_d    = timer + 20'd1;
    edge_cnt_d = edge_cnt;
    shift_d    = shift_q;
    dat_oe_d   = ps2_dat_oe;
    unique case (state)
      S_IDLE: begin
        timer_d    = '0;
        edge_cnt_d = '0;
        if (host.tx_valid) shift_d = {1'b1, ~^host.tx_data, host.tx_data};
      end
      // Start timeout counts from the first cycle the clock is released.
      S_RTS: timer_d = '0;
      S_WAIT_FIRST, S_SHIFT: begin
        if (clk_fall) begin
          dat_oe_d   = ~shift_q[0];
          shift_d    = {1'b0, shift_q[9:1]};
          edge_cnt_d = edge_cnt + 4'd1;
          // Transfer timeout counts from edge 1.
          if (state == S_WAIT_FIRST) timer_d = '0;
        end
      end
      default: ;
    endcase
    // Start bit goes low during the RTS overlap and stays until edge 1.
    if (state_d == S_RTS) dat_oe_d = 1'b1;
    if (state_d inside {S_IDLE, S_DONE, S_FAIL}) dat_oe_d = 1'b0;
    clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_RTS);
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = ~tx_ready_d;
    tx_done_d  = (state_d == S_DONE) || (state_d == S_FAIL);
    tx_error_d = (state_d == S_FAIL);
  end

  assign host.tx_ready = tx_ready_q;
  assign host.busy     = busy_q;
  assign host.tx_done  = tx_done_q;
  assign host.tx_error = tx_error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx. A PS/2 device model
// drives the open-drain lines; expected bits come from a frame model built
// from the byte (LSB-first data, odd parity, stop).
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH      = 40;
  localparam int START_TO = 600;
  localparam int XFER_TO  = 1500;

  logic clock   = 1'b0;
  logic resetn  = 1'b0;
  logic dev_clk = 1'b1;   // 0 = device pulls clock low
  logic dev_dat = 1'b1;   // 0 = device pulls data low
  logic ps2_clk_oe, ps2_dat_oe;
  logic ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx_if host ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START_TO),
    .XFER_TIMEOUT  (XFER_TO)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .host      (host),
    .ps2_clk_in(ps2_clk_line),
    .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0, start_cnt = 0, orphan_err = 0, long_done = 0;
  logic clk_oe_prev = 1'b0, done_prev = 1'b0;

  // Results captured by the most recent send / completion.
  logic       got_err;
  logic [1:0] got_oe;
  int         got_cyc;
  int         rel_cyc;

  always @(posedge clock) cyc <= cyc + 1;

  // Line monitor: counts transfers started and completion pulses.
  always @(negedge clock) begin
    if (host.tx_done === 1'b1) done_cnt++;
    if (host.tx_done === 1'b1 && done_prev) long_done++;
    if (host.tx_error === 1'b1 && host.tx_done !== 1'b1) orphan_err++;
    if (ps2_clk_oe === 1'b1 && !clk_oe_prev) start_cnt++;
    clk_oe_prev = (ps2_clk_oe === 1'b1);
    done_prev   = (host.tx_done === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame model: bits in line order are data[0..7], odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Issue a request and check the inhibit / RTS phase; returns in the first
  // cycle with the clock released (rel_cyc).
  task automatic start_send(input logic [7:0] b);
    int k, n_clk, n_dat;
    logic last_dat;
    k = 0;
    while (host.tx_ready !== 1'b1 && k < 100) begin @(negedge clock); k++; end
    check("ready_before", host.tx_ready, 1);
    host.tx_data  = b;
    host.tx_valid = 1'b1;
    @(negedge clock);
    host.tx_valid = 1'b0;
    check("accept_busy", host.busy, 1);
    check("accept_ready", host.tx_ready, 0);
    check("accept_clk_oe", ps2_clk_oe, 1);
    n_clk = 0; n_dat = 0; last_dat = 1'b0; k = 0;
    while (ps2_clk_oe === 1'b1 && k < INH + 50) begin
      n_clk++;
      if (ps2_dat_oe === 1'b1) n_dat++;
      last_dat = ps2_dat_oe;
      @(negedge clock);
      k++;
    end
    check("inhibit_len", n_clk, INH + 1);
    check("rts_overlap", n_dat, 1);
    check("rts_last", last_dat, 1);
    check("start_hold", ps2_dat_oe, 1);
    rel_cyc = cyc;
  endtask

  // Device clocking n_edges falling edges; checks dat_oe late in each low
  // phase of edges 1..10. On edge 11 it returns with the clock held low.
  task automatic device_clock(input logic [7:0] b, input bit ack, input int n_edges, input bit poke);
    logic [9:0] frame;
    logic       exp_oe;
    int         lo, hi;
    frame = frame_of(b);
    repeat ($urandom_range(4, 20)) @(negedge clock);
    for (int k = 1; k <= n_edges; k++) begin
      lo = $urandom_range(10, 20);
      hi = $urandom_range(10, 20);
      if (k == 11) begin
        dev_dat = ack ? 1'b0 : 1'b1;
        @(negedge clock);
        @(negedge clock);
      end
      dev_clk = 1'b0;
      if (k == 11) break;
      if (poke && k == 3) begin
        host.tx_data  = 8'hAA;
        host.tx_valid = 1'b1;
        @(negedge clock);
        host.tx_valid = 1'b0;
      end
      repeat (lo) @(negedge clock);
      exp_oe = !frame[k-1];
      check($sformatf("bit%0d_of_%02h", k, b), ps2_dat_oe, exp_oe);
      dev_clk = 1'b1;
      repeat (hi) @(negedge clock);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (host.tx_done !== 1'b1 && k < budget) begin @(negedge clock); k++; end
    check("done_seen", host.tx_done, 1);
    got_err = host.tx_error;
    got_oe  = {ps2_clk_oe, ps2_dat_oe};
    got_cyc = cyc;
    @(negedge clock);
    check("post_ready", host.tx_ready, 1);
    check("post_busy", host.busy, 0);
    check("post_done_low", host.tx_done, 0);
    check("post_err_low", host.tx_error, 0);
  endtask

  task automatic full_xfer(input logic [7:0] b, input bit ack, input bit poke);
    int pd, ps;
    pd = done_cnt;
    ps = start_cnt;
    start_send(b);
    device_clock(b, ack, 11, poke);
    if (ack) begin
      repeat (12) @(negedge clock);
      dev_clk = 1'b1;
      repeat (6) @(negedge clock);
      dev_dat = 1'b1;
      wait_done(200);
    end else begin
      wait_done(50);
      repeat (12) @(negedge clock);
      dev_clk = 1'b1;
    end
    check("xfer_error", got_err, ack ? 0 : 1);
    check("done_oe", got_oe, 0);
    repeat (20) @(negedge clock);
    check("one_done", done_cnt - pd, 1);
    check("one_start", start_cnt - ps, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         pd, ps;
    logic [7:0] rb;
    bit         ra;
    logic [9:0] fr;
    logic       exp_b;

    host.tx_data  = 8'h00;
    host.tx_valid = 1'b0;
    resetn        = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", host.tx_ready, 1);
    check("rst_busy", host.busy, 0);
    check("rst_done", host.tx_done, 0);
    check("rst_error", host.tx_error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // Directed sends: ack with parity 1, ack with parity 0, no-ack.
    full_xfer(8'hED, 1'b1, 1'b0);
    full_xfer(8'h01, 1'b1, 1'b0);
    full_xfer(8'hFF, 1'b0, 1'b0);

    // Device never clocks: fail exactly START_TO cycles after release.
    start_send(8'h5A);
    wait_done(START_TO + 100);
    check("start_to_cycles", got_cyc - rel_cyc, START_TO);
    check("start_to_err", got_err, 1);
    check("start_to_oe", got_oe, 0);

    // Device stalls after edge 5: transfer timeout.
    start_send(8'hC3);
    device_clock(8'hC3, 1'b1, 5, 1'b0);
    wait_done(XFER_TO + 200);
    check("xfer_to_err", got_err, 1);
    check("xfer_to_oe", got_oe, 0);
    check("xfer_to_late", (got_cyc - rel_cyc) > XFER_TO, 1);
    repeat (10) @(negedge clock);

    // Reset between edges 4 and 5, then a normal send.
    pd = done_cnt;
    start_send(8'h00);
    device_clock(8'h00, 1'b1, 4, 1'b0);
    fr = frame_of(8'h00);
    exp_b = !fr[3];
    check("pre_reset_dat_oe", ps2_dat_oe, exp_b);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_clk_oe", ps2_clk_oe, 0);
    check("async_rst_dat_oe", ps2_dat_oe, 0);
    @(negedge clock);
    check("in_rst_ready", host.tx_ready, 1);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("after_rst_ready", host.tx_ready, 1);
    check("after_rst_busy", host.busy, 0);
    check("rst_no_done", done_cnt - pd, 0);
    full_xfer(8'hF4, 1'b1, 1'b0);

    // 0xAA request during an active 0xED send is ignored.
    full_xfer(8'hED, 1'b1, 1'b1);
    ps = start_cnt;
    repeat (100) @(negedge clock);
    check("no_second_start", start_cnt - ps, 0);
    check("idle_after_poke", host.tx_ready, 1);

    // Randomized bytes and acknowledge behaviour.
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      full_xfer(rb, ra, 1'b0);
    end

    check("err_without_done", orphan_err, 0);
    check("done_pulse_width", long_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
